// File: rtl/double_dabble_pkg.sv
// rtl/double_dabble_pkg.sv - shared states, BCD constants and counter sizing for double_dabble_seq
package double_dabble_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCA,
    PRONTO
  } estado_t;

  localparam logic [3:0] LIMIAR_BCD = 4'd5;
  localparam logic [3:0] AJUSTE_BCD = 4'd3;
  localparam logic [3:0] DIGITO_MAX = 4'd9;

  // Counter must hold the value LARGURA itself, not just LARGURA-1.
  function automatic int largura_contador(input int largura);
    return (largura < 1) ? 1 : $clog2(largura + 1);
  endfunction

endpackage

// File: rtl/corretor_digito_bcd.sv
// rtl/corretor_digito_bcd.sv - one BCD digit pre-shift correction (add 3 when >= 5)
module corretor_digito_bcd
  import double_dabble_pkg::*;
(
  input  logic [3:0] digito,
  output logic [3:0] corrigido
);

  assign corrigido = (digito >= LIMIAR_BCD) ? digito + AJUSTE_BCD : digito;

endmodule

// File: rtl/double_dabble_seq.sv
// rtl/double_dabble_seq.sv - bit-serial binary-to-BCD converter; DOUBLE_DABBLE_APAGAR_EN adds Apagar
module double_dabble_seq
  import double_dabble_pkg::*;
#(
  parameter int LARGURA = 7,
  parameter int DIGITOS = 3
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   In_valid,
  output logic                   In_ready,
  input  logic [LARGURA-1:0]     Binario,
  output logic                   Out_valid,
  input  logic                   Out_ready,
  output logic [4*DIGITOS-1:0]   Bcd,
  output logic                   Overflow
`ifdef DOUBLE_DABBLE_APAGAR_EN
  ,
  output logic [DIGITOS-1:0]     Apagar
`endif
);

  localparam int CW = largura_contador(LARGURA);
  localparam logic [CW-1:0] CARGA = CW'(LARGURA);
  localparam logic [4*DIGITOS-1:0] NOVES = {DIGITOS{DIGITO_MAX}};

  estado_t estado, proximo;

  logic [LARGURA-1:0]   deslocador, deslocador_prox;
  logic [4*DIGITOS-1:0] digitos, ajustados, digitos_prox;
  logic [CW-1:0]        contador;
  logic                 estouro, bit_saida, digito_invalido, saturar;
  logic                 ultimo;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_corretor
    corretor_digito_bcd u_corretor (
      .digito    (digitos[4*g +: 4]),
      .corrigido (ajustados[4*g +: 4])
    );
  end

  assign {bit_saida, digitos_prox, deslocador_prox} = {ajustados, deslocador, 1'b0};
  assign ultimo = (contador == CW'(1));

  always_comb begin
    digito_invalido = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (digitos_prox[4*i +: 4] > DIGITO_MAX) digito_invalido = 1'b1;
    end
  end

  assign saturar = estouro | bit_saida | digito_invalido;

  always_ff @(posedge Clock) begin
    if (!Reset_n) estado <= OCIOSO;
    else          estado <= proximo;
  end

  always_comb begin
    proximo   = estado;
    In_ready  = 1'b0;
    Out_valid = 1'b0;
    case (estado)
      OCIOSO: begin
        In_ready = 1'b1;
        if (In_valid) proximo = DESLOCA;
      end
      DESLOCA: begin
        if (ultimo) proximo = PRONTO;
      end
      PRONTO: begin
        Out_valid = 1'b1;
        if (Out_ready) proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      deslocador <= '0;
      digitos    <= '0;
      contador   <= '0;
      estouro    <= 1'b0;
      Bcd        <= '0;
      Overflow   <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (In_valid) begin
            deslocador <= Binario;
            digitos    <= '0;
            estouro    <= 1'b0;
            contador   <= CARGA;
          end
        end
        DESLOCA: begin
          deslocador <= deslocador_prox;
          digitos    <= digitos_prox;
          estouro    <= estouro | bit_saida;
          contador   <= contador - CW'(1);
          // Published result only changes on the final shift.
          if (ultimo) begin
            Bcd      <= saturar ? NOVES : digitos_prox;
            Overflow <= saturar;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DOUBLE_DABBLE_APAGAR_EN
  logic [DIGITOS-1:0] apagar_prox;
  logic               zeros_acima;

  always_comb begin
    apagar_prox = '0;
    zeros_acima = 1'b1;
    for (int i = DIGITOS - 1; i >= 1; i--) begin
      zeros_acima    = zeros_acima & (digitos_prox[4*i +: 4] == 4'd0);
      apagar_prox[i] = zeros_acima & ~saturar;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n)                      Apagar <= '0;
    else if (estado == DESLOCA && ultimo) Apagar <= apagar_prox;
  end
`endif

endmodule

// File: doc/double_dabble_seq.md
Name: double_dabble_seq

Overview:
Sequential, parametrised binary-to-BCD converter. It runs the shift-add-3 (double dabble) algorithm one bit per clock instead of as an unrolled combinational chain. Input binary width and BCD digit count are generalised, a valid/ready handshake is added on both sides, and an overflow flag is produced. It sits between the counter/measurement datapath and the 7-segment display drivers.

Parameters:
LARGURA, 7, width in bits of the binary input (>=1)
DIGITOS, 3, number of 4-bit BCD output digits (>=1)

Ports:
Clock  input  1  single system clock, all logic on rising edge
Reset_n  input  1  synchronous, active-low reset, sampled on rising edge of Clock
In_valid  input  1  Binario is valid this cycle
In_ready  output  1  converter idle and able to accept
Binario  input  LARGURA  unsigned binary value
Out_valid  output  1  BCD result valid
Out_ready  input  1  consumer accepts result
Bcd  output  4*DIGITOS  packed BCD; digit 0 (units) in bits [3:0], digit i in [4i+3:4i]
Overflow  output  1  value exceeded 10^DIGITOS - 1

Behaviour:
- Reset (Reset_n=0 at an edge): state OCIOSO; Bcd=0, Out_valid=0, Overflow=0, internal shift and bit counters cleared. In_ready=1 from the first cycle after reset.
- Reset takes priority over everything, including mid-conversion. A conversion in progress is discarded with no output.
- States:
  - OCIOSO: In_ready=1. In_valid=1 → latch Binario into a shift register, clear digit registers and overflow, load bit counter = LARGURA, go to DESLOCA. In_valid=0 → stay.
  - DESLOCA: In_ready=0. Each cycle:
    - every digit >=5 gets +3 (mod 16);
    - the whole {digits, shift register} shifts left 1, with the MSB of the shift register entering digit 0 bit 0;
    - the bit leaving digit DIGITOS-1 bit 3 is ORed into a sticky overflow bit;
    - counter decrements.
    - On the cycle the counter reaches 1 (last shift), go to PRONTO.
  - PRONTO: Out_valid=1, In_ready=0. Bcd and Overflow held stable until Out_ready=1, then go to OCIOSO on that edge. Out_valid falls the next cycle.
- Latency: In_valid accepted at edge N → Out_valid=1 after edge N+LARGURA, i.e. LARGURA+1 cycles including the accept cycle. Throughput is one conversion per LARGURA+2 cycles at best; no back-to-back accept from PRONTO.
- Overflow: if the sticky bit is set, or the value would otherwise exceed 10^DIGITOS-1, then Bcd = all digits 9 (saturated) and Overflow=1. Otherwise Bcd is the exact decimal value and Overflow=0.
- In_valid while In_ready=0 is ignored and Binario is not sampled.
- Out_ready while Out_valid=0 has no effect.
- Bcd keeps its last result after Out_valid falls. It is updated only on entry to PRONTO.
- Digit registers never hold values >9 when Out_valid=1.

Optional Feature:
DOUBLE_DABBLE_APAGAR_EN:
- Defined: adds output Apagar [DIGITOS-1:0], registered alongside Bcd and reset to 0.
  - Bit i (i>=1) is 1 when digit i and all higher digits are zero (leading-zero blanking for displays).
  - Bit 0 is always 0.
  - All bits are 0 when Overflow=1.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package double_dabble_pkg holds:
  - state enum {OCIOSO, DESLOCA, PRONTO};
  - constants LIMIAR_BCD=4'd5, AJUSTE_BCD=4'd3, DIGITO_MAX=4'd9;
  - a function computing the bit-counter width from LARGURA.
- One sub-module, corretor_digito_bcd: a 4-bit combinational add-3-if->=5, instantiated DIGITOS times via generate.

Test Plan:
- Defaults (7,3): Binario=127 → Bcd=12'h127, Overflow=0, Out_valid exactly 8 cycles after the accept edge.
- Defaults: Binario=0 → Bcd=12'h000. With the macro defined: Apagar=3'b110.
- LARGURA=7, DIGITOS=2: Binario=99 → Bcd=8'h99, Overflow=0. Then Binario=100 → Bcd=8'h99, Overflow=1.
- LARGURA=16, DIGITOS=5: Binario=65535 → Bcd=20'h65535, latency 17 cycles. Binario=1000 with the macro defined → Apagar=5'b10000.
- Backpressure: hold Out_ready=0 for 5 cycles in PRONTO → Out_valid, Bcd and Overflow stable. Pulse In_valid with 42 during that window → ignored, In_ready=0.
- Reset_n=0 at the 3rd DESLOCA cycle of 127 → next cycle Out_valid=0, Bcd=0, In_ready=1. A new request with 45 yields 12'h045.
